// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
//   Shared constants and types for the two-port SRAM arbiter.
//   DATA_W : SRAM word width
//   ADDR_W : SRAM word address width
//   DEPTH  : number of words zero-filled after reset
//   state_t: arbiter FSM state (zero-fill sweep, then normal service)
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin grant, purely combinational.
//   valid[1:0] : request lines
//   prio       : round-robin pointer, the requester that wins a tie
//                (the one that was not granted last)
//   grant[1:0] : one-hot grant, all zero when nothing is requesting
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        if (valid == 2'b11) begin
            grant = prio ? 2'b10 : 2'b01;
        end else begin
            // Zero or one requester: pass the request straight through.
            grant = valid;
        end
    end

endmodule

// File: rtl/sram_arb_2p.sv
// ---------------------------------------------------------------------------
// sram_arb_2p
//   Shares one single-port synchronous SRAM between two requesters.
//   After reset the whole array is swept with zeros (INIT), then requests are
//   served round-robin, at most one per cycle (RUN).
//
//   CLK, RESET_N          : clock (rising edge), async active-low reset
//   reqN_valid/wen/addr/wdata : request from requester N (wen 1=read, 0=write)
//   reqN_ready            : request N accepted on this edge when valid&ready
//   rvalid0/rvalid1       : one-cycle read response strobe per requester
//   rdata                 : shared read data, holds between responses
//   sram_CEN/WEN/A/D      : SRAM command (CEN active-low, WEN 1=read)
//   sram_Q                : SRAM read data, valid the cycle after a read edge
//   init_done             : zero-fill complete, sticky until reset
// ---------------------------------------------------------------------------
module sram_arb_2p
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = sram_arb_pkg::DATA_W,
    parameter int ADDR_W = sram_arb_pkg::ADDR_W,
    parameter int DEPTH  = sram_arb_pkg::DEPTH
) (
    input  logic              CLK,
    input  logic              RESET_N,

    input  logic              req0_valid,
    input  logic              req0_wen,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_wen,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,

    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,

    output logic              sram_CEN,
    output logic              sram_WEN,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_D,
    input  logic [DATA_W-1:0] sram_Q,

    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_q;        // requester favoured on a tie
    logic [1:0]        rd_pend_q;    // read accepted last edge, per requester
    logic [1:0]        grant;

    // Requests are only visible to the arbiter once the sweep has finished.
    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid} & {2{state_q == ST_RUN}}),
        .prio  (ptr_q),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sram_CEN = 1'b1;
        sram_WEN = 1'b1;
        sram_A   = '0;
        sram_D   = '0;

        unique case (state_q)
            ST_INIT: begin
                // The SRAM must stay idle while reset is held, even though the
                // state register already reads INIT.
                sram_CEN = ~RESET_N;
                sram_WEN = 1'b0;
                sram_A   = cnt_q;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (|grant) begin
                    sram_CEN = 1'b0;
                    sram_WEN = grant[1] ? req1_wen   : req0_wen;
                    sram_A   = grant[1] ? req1_addr  : req0_addr;
                    sram_D   = grant[1] ? req1_wdata : req0_wdata;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            rd_pend_q <= 2'b00;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
            init_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;

            if (state_d == ST_RUN) begin
                init_done <= 1'b1;
            end

            // After serving requester 0 the tie goes to requester 1, and
            // vice versa; no handshake leaves the pointer alone.
            if (|grant) begin
                ptr_q <= grant[0];
            end

            // Read pipeline: SRAM samples the address on the accept edge,
            // sram_Q is captured on the edge after that.
            rd_pend_q <= grant & {req1_wen, req0_wen};
            rvalid0   <= rd_pend_q[0];
            rvalid1   <= rd_pend_q[1];
            if (|rd_pend_q) begin
                rdata <= sram_Q;
            end
        end
    end

endmodule
